cr_mux_arbiter: RTL and testbench

- Parametrised successor of the control-register source mux in Master Control.
- Merges N_SRC control-register writers (coefficient loader, start/stop sequencer, clock generator, host, ...) onto one registered write port toward the correlator control registers.
- Adds per-source single-entry buffering, manual or round-robin selection, valid/ready output handshake, per-source acknowledge and overflow flags.

---
 rtl/cr_pkg.sv | 16 +
 rtl/cr_mux_arbiter_if.sv | 32 +++
 rtl/cr_rr_arbiter.sv | 29 ++
 rtl/cr_mux_arbiter.sv | 107 ++++++++++
 tb/tb_cr_mux_arbiter.sv | 199 +++++++++++++++++++
 5 files changed

// File: rtl/cr_pkg.sv
// Shared control-register definitions: word width, legacy source indices, output slot states.
package cr_pkg;

    localparam int unsigned CR_DATA_W     = 32;

    localparam int unsigned CR_SRC_COEFF  = 0;
    localparam int unsigned CR_SRC_STOP   = 1;
    localparam int unsigned CR_SRC_START  = 2;
    localparam int unsigned CR_SRC_CLKGEN = 3;

    typedef enum logic {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_state_t;

endpackage

// File: rtl/cr_mux_arbiter_if.sv
// Source-side and downstream-side signals of the control-register mux/arbiter.
interface cr_mux_arbiter_if
    import cr_pkg::*;
#(
    parameter int unsigned N_SRC  = 4,
    parameter int unsigned DATA_W = CR_DATA_W,
    parameter int unsigned SEL_W  = 2
);
    logic                      rr_en;
    logic [SEL_W-1:0]          cr_sel;
    logic [N_SRC-1:0]          src_we;
    logic [N_SRC*DATA_W-1:0]   src_cr;
    logic [N_SRC-1:0]          src_ack;
    logic [N_SRC-1:0]          src_pend;
    logic [N_SRC-1:0]          src_ovf;
    logic                      ovf_clr;
    logic                      we;
    logic [DATA_W-1:0]         cr;
    logic                      cr_ready;
    logic                      busy;

    modport master (
        output rr_en, cr_sel, src_we, src_cr, ovf_clr, cr_ready,
        input  src_ack, src_pend, src_ovf, we, cr, busy
    );

    modport slave (
        input  rr_en, cr_sel, src_we, src_cr, ovf_clr, cr_ready,
        output src_ack, src_pend, src_ovf, we, cr, busy
    );

endinterface

// File: rtl/cr_rr_arbiter.sv
// Combinational round-robin picker: first pending source at or above ptr, wrapping at N_SRC-1.
module cr_rr_arbiter #(
    parameter int unsigned N_SRC = 4,
    parameter int unsigned SEL_W = 2
) (
    input  logic [N_SRC-1:0] pend,
    input  logic [SEL_W-1:0] ptr,
    output logic [N_SRC-1:0] grant,
    output logic [SEL_W-1:0] ptr_nx
);

    always_comb begin
        logic             found;
        logic [SEL_W-1:0] idx;
        grant  = '0;
        ptr_nx = ptr;
        found  = 1'b0;
        idx    = '0;
        for (int unsigned k = 0; k < N_SRC; k++) begin
            idx = SEL_W'((32'(ptr) + k) % N_SRC);
            if (!found && pend[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                ptr_nx     = SEL_W'((32'(idx) + 1) % N_SRC);
            end
        end
    end

endmodule

// File: rtl/cr_mux_arbiter.sv
// Merges N_SRC control-register writers onto one registered valid/ready write port,
// with single-entry per-source buffering, manual or round-robin selection and overflow flags.
module cr_mux_arbiter
    import cr_pkg::*;
#(
    parameter int unsigned N_SRC  = 4,
    parameter int unsigned DATA_W = CR_DATA_W,
    parameter int unsigned SEL_W  = (N_SRC > 1) ? $clog2(N_SRC) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    cr_mux_arbiter_if.slave  bus
);

    slot_state_t       state, state_nx;
    logic [N_SRC-1:0]  pend, ovf, ack;
    logic [N_SRC-1:0]  rr_grant, man_grant, grant, capture, ovf_evt;
    logic [SEL_W-1:0]  ptr, rr_ptr_nx;
    logic [DATA_W-1:0] hold [N_SRC];
    logic [DATA_W-1:0] cr_q, grant_data;
    logic              loadable, any_grant;

    cr_rr_arbiter #(
        .N_SRC (N_SRC),
        .SEL_W (SEL_W)
    ) u_rr (
        .pend   (pend),
        .ptr    (ptr),
        .grant  (rr_grant),
        .ptr_nx (rr_ptr_nx)
    );

    // Grant only when the output slot can take a word; a freed holding register may recapture at once.
    always_comb begin
        man_grant = '0;
        for (int unsigned i = 0; i < N_SRC; i++) begin
            man_grant[i] = pend[i] && (bus.cr_sel == SEL_W'(i));
        end
        loadable   = (state == SLOT_EMPTY) || bus.cr_ready;
        grant      = '0;
        if (loadable) begin
            grant = bus.rr_en ? rr_grant : man_grant;
        end
        any_grant  = |grant;
        grant_data = '0;
        for (int unsigned i = 0; i < N_SRC; i++) begin
            if (grant[i]) begin
                grant_data = hold[i];
            end
        end
        capture = bus.src_we & (~pend | grant);
        ovf_evt = bus.src_we & pend & ~grant;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= SLOT_EMPTY;
        end else begin
            state <= state_nx;
        end
    end

    // Output slot: a grant always (re)fills it, so a FULL slot drained with cr_ready stays FULL back-to-back.
    always_comb begin
        state_nx = state;
        case (state)
            SLOT_EMPTY: if (any_grant) state_nx = SLOT_FULL;
            SLOT_FULL:  if (bus.cr_ready && !any_grant) state_nx = SLOT_EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pend <= '0;
            ovf  <= '0;
            ack  <= '0;
            cr_q <= '0;
            ptr  <= '0;
            for (int unsigned i = 0; i < N_SRC; i++) begin
                hold[i] <= '0;
            end
        end else begin
            ack  <= grant;
            pend <= capture | (pend & ~grant);
            ovf  <= ovf_evt | (ovf & ~{N_SRC{bus.ovf_clr}});
            if (any_grant) begin
                cr_q <= grant_data;
            end
            if (bus.rr_en && any_grant) begin
                ptr <= rr_ptr_nx;
            end
            for (int unsigned i = 0; i < N_SRC; i++) begin
                if (capture[i]) begin
                    hold[i] <= bus.src_cr[i*DATA_W +: DATA_W];
                end
            end
        end
    end

    assign bus.src_ack  = ack;
    assign bus.src_pend = pend;
    assign bus.src_ovf  = ovf;
    assign bus.we       = (state == SLOT_FULL);
    assign bus.cr       = cr_q;
    assign bus.busy     = (|pend) || (state == SLOT_FULL);

endmodule

// File: tb/tb_cr_mux_arbiter.sv
// Directed self-checking bench for cr_mux_arbiter (N_SRC=4, DATA_W=32).
module tb_cr_mux_arbiter;
    import cr_pkg::*;

    localparam int unsigned N  = 4;
    localparam int unsigned DW = 32;
    localparam int unsigned SW = 2;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    cr_mux_arbiter_if #(.N_SRC(N), .DATA_W(DW), .SEL_W(SW)) bus ();

    cr_mux_arbiter #(.N_SRC(N), .DATA_W(DW), .SEL_W(SW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock; sample 1 time unit after the edge and drop single-cycle strobes.
    task automatic tick();
        @(posedge clk);
        #1;
        bus.src_we  = '0;
        bus.ovf_clr = 1'b0;
    endtask

    task automatic wr(input int unsigned i, input logic [31:0] d);
        bus.src_we[i]          = 1'b1;
        bus.src_cr[i*DW +: DW] = d;
    endtask

    task automatic chk_out(input string tag, input logic w, input logic [31:0] d, input logic [3:0] a);
        chk({tag, "_we"},  32'(bus.we), 32'(w));
        chk({tag, "_cr"},  bus.cr, d);
        chk({tag, "_ack"}, 32'(bus.src_ack), 32'(a));
    endtask

    initial begin
        checks       = 0;
        errors       = 0;
        rst_n        = 1'b0;
        bus.rr_en    = 1'b0;
        bus.cr_sel   = '0;
        bus.src_we   = '0;
        bus.src_cr   = '0;
        bus.ovf_clr  = 1'b0;
        bus.cr_ready = 1'b1;
        tick();
        tick();
        rst_n = 1'b1;

        chk_out("reset", 1'b0, 32'h0, 4'b0000);
        chk("reset_pend", 32'(bus.src_pend), 32'h0);
        chk("reset_ovf",  32'(bus.src_ovf),  32'h0);
        chk("reset_busy", 32'(bus.busy),     32'h0);

        // Manual single write
        bus.cr_sel = 2'd2;
        wr(CR_SRC_START, 32'hDEADBEEF);
        tick();
        chk("man1_pend", 32'(bus.src_pend), 32'b0100);
        chk("man1_we_t1", 32'(bus.we), 32'h0);
        tick();
        chk_out("man1_t2", 1'b1, 32'hDEADBEEF, 4'b0100);
        tick();
        chk("man1_we_t3",  32'(bus.we),      32'h0);
        chk("man1_ack_t3", 32'(bus.src_ack), 32'h0);
        chk("man1_busy",   32'(bus.busy),    32'h0);

        // Manual hold
        bus.cr_sel = 2'd0;
        wr(1, 32'h11);
        wr(3, 32'h33);
        tick();
        tick();
        chk("hold_we",   32'(bus.we),       32'h0);
        chk("hold_pend", 32'(bus.src_pend), 32'b1010);
        chk("hold_busy", 32'(bus.busy),     32'h1);
        bus.cr_sel = 2'd3;
        tick();
        chk_out("hold_s3", 1'b1, 32'h33, 4'b1000);
        bus.cr_sel = 2'd1;
        tick();
        chk_out("hold_s1", 1'b1, 32'h11, 4'b0010);
        chk("hold_pend_end", 32'(bus.src_pend), 32'h0);
        tick();
        chk("hold_we_end", 32'(bus.we), 32'h0);

        // Round-robin from pointer 0
        bus.rr_en = 1'b1;
        for (int unsigned i = 0; i < N; i++) wr(i, 32'hA0 + i);
        tick();
        tick(); chk_out("rr0_a", 1'b1, 32'hA0, 4'b0001);
        tick(); chk_out("rr0_b", 1'b1, 32'hA1, 4'b0010);
        tick(); chk_out("rr0_c", 1'b1, 32'hA2, 4'b0100);
        tick(); chk_out("rr0_d", 1'b1, 32'hA3, 4'b1000);
        tick(); chk("rr0_idle", 32'(bus.we), 32'h0);

        // A lone grant to source 1 moves the pointer to 2
        wr(1, 32'hB1);
        tick();
        tick(); chk_out("rr_b1", 1'b1, 32'hB1, 4'b0010);
        tick();
        for (int unsigned i = 0; i < N; i++) wr(i, 32'hA0 + i);
        tick();
        tick(); chk_out("rr2_a", 1'b1, 32'hA2, 4'b0100);
        tick(); chk_out("rr2_b", 1'b1, 32'hA3, 4'b1000);
        tick(); chk_out("rr2_c", 1'b1, 32'hA0, 4'b0001);
        tick(); chk_out("rr2_d", 1'b1, 32'hA1, 4'b0010);
        tick(); chk("rr2_idle", 32'(bus.we), 32'h0);

        // Backpressure: pointer at 2 picks source 0 first
        bus.cr_ready = 1'b0;
        wr(0, 32'hC0);
        wr(1, 32'hC1);
        tick();
        tick(); chk_out("bp_load", 1'b1, 32'hC0, 4'b0001);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk_out($sformatf("bp_stall%0d", i), 1'b1, 32'hC0, 4'b0000);
        end
        chk("bp_pend", 32'(bus.src_pend), 32'b0010);
        bus.cr_ready = 1'b1;
        tick(); chk_out("bp_next", 1'b1, 32'hC1, 4'b0010);
        tick(); chk("bp_idle", 32'(bus.we), 32'h0);

        // Overflow
        bus.rr_en  = 1'b0;
        bus.cr_sel = 2'd0;
        wr(1, 32'h5);
        tick();
        chk("ovf_none", 32'(bus.src_ovf), 32'h0);
        wr(1, 32'h6);
        tick();
        chk("ovf_set",  32'(bus.src_ovf),  32'b0010);
        chk("ovf_pend", 32'(bus.src_pend), 32'b0010);
        bus.cr_sel = 2'd1;
        tick(); chk_out("ovf_dlv", 1'b1, 32'h5, 4'b0010);
        tick(); chk("ovf_we_end", 32'(bus.we), 32'h0);
        chk("ovf_sticky", 32'(bus.src_ovf), 32'b0010);
        bus.ovf_clr = 1'b1;
        tick();
        chk("ovf_clr", 32'(bus.src_ovf), 32'h0);
        bus.cr_sel = 2'd0;
        wr(1, 32'h7);
        tick();
        wr(1, 32'h8);
        bus.ovf_clr = 1'b1;
        tick();
        chk("ovf_clr_vs_evt", 32'(bus.src_ovf), 32'b0010);

        // Reset mid-operation
        bus.cr_ready = 1'b0;
        wr(0, 32'hE0);
        wr(2, 32'hE2);
        tick();
        chk("rst_pre_pend", 32'(bus.src_pend), 32'b0111);
        tick();
        chk_out("rst_pre", 1'b1, 32'hE0, 4'b0001);
        chk("rst_pre_pend2", 32'(bus.src_pend), 32'b0110);
        rst_n = 1'b0;
        tick();
        chk_out("rst_mid", 1'b0, 32'h0, 4'b0000);
        chk("rst_mid_pend", 32'(bus.src_pend), 32'h0);
        chk("rst_mid_ovf",  32'(bus.src_ovf),  32'h0);
        chk("rst_mid_busy", 32'(bus.busy),     32'h0);
        rst_n        = 1'b1;
        bus.cr_ready = 1'b1;
        tick();
        chk_out("rst_post", 1'b0, 32'h0, 4'b0000);

        // Pointer restarts at 0 after reset
        bus.rr_en = 1'b1;
        wr(3, 32'hF3);
        wr(1, 32'hF1);
        tick();
        tick(); chk_out("rst_ptr_a", 1'b1, 32'hF1, 4'b0010);
        tick(); chk_out("rst_ptr_b", 1'b1, 32'hF3, 4'b1000);
        tick(); chk("rst_ptr_idle", 32'(bus.we), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
